// File: rtl/reg_exmem_skid.sv
// rtl/reg_exmem_skid.sv - two-entry EX/MEM skid buffer carrying {OpCode, Rd, AluRes, StData}
// in_ready is registered from the next-state count so out_ready never reaches it combinationally.
module reg_exmem_skid #(
   parameter int W_OP  = 5,
   parameter int W_REG = 9,
   parameter int W_DAT = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_OP-1:0]  OpCode,
   input  logic [W_REG-1:0] Rd,
   input  logic [W_DAT-1:0] AluRes,
   input  logic [W_DAT-1:0] StData,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OP-1:0]  OpCodeOut,
   output logic [W_REG-1:0] RdOut,
   output logic [W_DAT-1:0] AluResOut,
   output logic [W_DAT-1:0] StDataOut
);

   localparam int W_ENT = W_OP + W_REG + 2 * W_DAT;

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             in_ready_q, in_ready_d;
   logic [W_ENT-1:0] ent0_q, ent0_d;
   logic [W_ENT-1:0] ent1_q, ent1_d;
   logic [W_ENT-1:0] wr_ent;
   logic [W_ENT-1:0] head;
   logic             push;
   logic             pop;

   assign wr_ent = {OpCode, Rd, AluRes, StData};
   assign push   = in_valid && in_ready_q;
   assign pop    = (count_q != 2'd0) && out_ready;

   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            if (wr_ptr_q) ent1_d = wr_ent;
            else          ent0_d = wr_ent;
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b1;
         ent0_q     <= '0;
         ent1_q     <= '0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_ready_q <= in_ready_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
      end
   end

   // Stale storage is masked so an empty buffer always presents zeros.
   assign out_valid = (count_q != 2'd0);
   assign in_ready  = in_ready_q;
   assign head      = !out_valid ? '0 : (rd_ptr_q ? ent1_q : ent0_q);
   assign {OpCodeOut, RdOut, AluResOut, StDataOut} = head;

endmodule

// File: tb/tb_reg_exmem_skid.sv
// tb/tb_reg_exmem_skid.sv - queue-model bench for reg_exmem_skid with directed and random traffic
module tb_reg_exmem_skid;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [4:0]  OpCode, OpCodeOut;
   logic [8:0]  Rd, RdOut;
   logic [19:0] AluRes, StData, AluResOut, StDataOut;

   always #5 clk = ~clk;

   reg_exmem_skid #(.W_OP(5), .W_REG(9), .W_DAT(20)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .OpCode(OpCode), .Rd(Rd), .AluRes(AluRes), .StData(StData),
      .out_valid(out_valid), .out_ready(out_ready),
      .OpCodeOut(OpCodeOut), .RdOut(RdOut), .AluResOut(AluResOut), .StDataOut(StDataOut)
   );

   typedef struct {
      logic [4:0]  op;
      logic [8:0]  rd;
      logic [19:0] alu;
      logic [19:0] st;
   } ent_t;

   ent_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
   endtask

   // Model: a bounded queue of at most two entries.
   always @(negedge rst) q.delete();

   always @(posedge clk) begin
      if (rst) begin
         ent_t e, tmp;
         bit   acc, pp;
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         e.op = OpCode; e.rd = Rd; e.alu = AluRes; e.st = StData;
         if (flush) q.delete();
         else begin
            if (pp) tmp = q.pop_front();
            if (acc) q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      ent_t h;
      h = '{default: '0};
      if (q.size() > 0) h = q[0];
      check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      check("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
      check("OpCodeOut", {59'd0, OpCodeOut}, {59'd0, h.op});
      check("RdOut",     {55'd0, RdOut},     {55'd0, h.rd});
      check("AluResOut", {44'd0, AluResOut}, {44'd0, h.alu});
      check("StDataOut", {44'd0, StDataOut}, {44'd0, h.st});
   end

   task automatic drive(input logic v, input logic [4:0] op, input logic [8:0] rd,
                        input logic [19:0] alu, input logic [19:0] st);
      in_valid = v; OpCode = op; Rd = rd; AluRes = alu; StData = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0);
      repeat (2) tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check("rst_alu",       {44'd0, AluResOut}, 64'd0);

      // Single push/pop right after reset release
      rst = 1'b1; out_ready = 1'b1;
      drive(1'b1, 5'd3, 9'd1, 20'd11, 20'd2);
      tick();
      check("t1_valid", {63'd0, out_valid}, 64'd1);
      check("t1_op",    {59'd0, OpCodeOut}, 64'd3);
      check("t1_rd",    {55'd0, RdOut},     64'd1);
      check("t1_alu",   {44'd0, AluResOut}, 64'd11);
      check("t1_st",    {44'd0, StDataOut}, 64'd2);
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0);
      tick();
      check("t1_drain_valid", {63'd0, out_valid}, 64'd0);
      check("t1_drain_op",    {59'd0, OpCodeOut}, 64'd0);

      // Fill to two, third blocked, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 5'd3, 9'd1, 20'd11, 20'd0);  tick();
      drive(1'b1, 5'd11, 9'd6, 20'd14, 20'd0); tick();
      check("t2_full_ready", {63'd0, in_ready}, 64'd0);
      drive(1'b1, 5'd7, 9'd9, 20'd128, 20'd0); tick();
      check("t2_head_hold", {59'd0, OpCodeOut}, 64'd3);
      out_ready = 1'b1; tick();
      check("t2_pop1_op",    {59'd0, OpCodeOut}, 64'd11);
      check("t2_pop1_ready", {63'd0, in_ready},  64'd1);
      tick();
      check("t2_third_op",  {59'd0, OpCodeOut}, 64'd7);
      check("t2_third_alu", {44'd0, AluResOut}, 64'd128);
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0); tick();

      // Simultaneous push and pop at count 1
      out_ready = 1'b0;
      drive(1'b1, 5'd3, 9'd2, 20'd5, 20'd6);  tick();
      out_ready = 1'b1;
      drive(1'b1, 5'd11, 9'd4, 20'd7, 20'd8); tick();
      check("t3_op",    {59'd0, OpCodeOut}, 64'd11);
      check("t3_valid", {63'd0, out_valid}, 64'd1);
      check("t3_ready", {63'd0, in_ready},  64'd1);
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0); tick();

      // Flush at count 2 with a push pending
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 9'd1, 20'd1, 20'd1); tick();
      drive(1'b1, 5'd2, 9'd2, 20'd2, 20'd2); tick();
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 5'd9, 9'd9, 20'd9, 20'd9); tick();
      flush = 1'b0;
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0);
      check("t4_valid", {63'd0, out_valid}, 64'd0);
      check("t4_ready", {63'd0, in_ready},  64'd1);
      check("t4_op",    {59'd0, OpCodeOut}, 64'd0);
      tick();
      check("t4_lost", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset between edges at count 2
      out_ready = 1'b0;
      drive(1'b1, 5'd4, 9'd4, 20'd4, 20'd4); tick();
      drive(1'b1, 5'd5, 9'd5, 20'd5, 20'd5); tick();
      drive(1'b0, 5'd0, 9'd0, 20'd0, 20'd0);
      #1 rst = 1'b0;
      #1;
      check("t5_valid", {63'd0, out_valid}, 64'd0);
      check("t5_ready", {63'd0, in_ready},  64'd1);
      check("t5_alu",   {44'd0, AluResOut}, 64'd0);
      #1 rst = 1'b1;
      tick();

      // Random traffic against the model
      for (int i = 0; i < 1000; i++) begin
         r = $urandom();
         in_valid  = r[0] | r[1];
         out_ready = r[2] | r[3];
         flush     = (r[9:4] == 6'd0);
         r = $urandom(); OpCode = r[4:0]; Rd = r[13:5];
         r = $urandom(); AluRes = r[19:0];
         r = $urandom(); StData = r[19:0];
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
